// File: rtl/fractal_scheduler.sv
// Mandelbrot frame sequencer: raster-walks the view window, issues pixels
// to the divergence pipeline and turns returning results into frame writes.
module fractal_scheduler #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ISSUE_DIV  = 6,
  parameter int PIPE_DEPTH = 62,
  parameter int ADDR_W     = 19
) (
  input  logic              Clk_100M,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       cfg_startX,
  input  logic [15:0]       cfg_startY,
  input  logic [15:0]       cfg_stepX,
  input  logic [15:0]       cfg_stepY,
  input  logic [7:0]        div_in,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam int DW = (ISSUE_DIV > 1) ? $clog2(ISSUE_DIV) : 1;
  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [DW-1:0]   DIV_MAX = DW'(ISSUE_DIV - 1);
  localparam logic [CW-1:0]   COL_MAX = CW'(H_RES - 1);
  localparam logic [RW-1:0]   ROW_MAX = RW'(V_RES - 1);
  localparam logic [ADDR_W:0] NPIX    = (ADDR_W + 1)'(H_RES * V_RES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]         r_sx;
  logic [15:0]         r_stx;
  logic [15:0]         r_sty;
  logic [15:0]         r_xacc;
  logic [15:0]         r_yacc;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [DW-1:0]       r_div;
  logic [ADDR_W:0]     r_wcnt;
  logic [PIPE_DEPTH-1:0] r_vsr;

  logic w_accept;
  logic w_issue;
  logic w_last;
  logic w_tail;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_issue  = (r_state == S_ISSUE) && (r_div == DIV_MAX);
  assign w_last   = w_issue && (r_col == COL_MAX) && (r_row == ROW_MAX);
  assign w_tail   = r_vsr[PIPE_DEPTH-1];

  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_wcnt == NPIX) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_sx      <= '0;
      r_stx     <= '0;
      r_sty     <= '0;
      r_xacc    <= '0;
      r_yacc    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_div     <= '0;
      r_wcnt    <= '0;
      r_vsr     <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= (w_next != S_IDLE);
      done      <= (w_next == S_DONE);
      r_vsr     <= (r_vsr << 1) | PIPE_DEPTH'(pix_valid);

      if (w_accept) begin
        r_sx   <= cfg_startX;
        r_stx  <= cfg_stepX;
        r_sty  <= cfg_stepY;
        r_xacc <= cfg_startX;
        r_yacc <= cfg_startY;
        r_col  <= '0;
        r_row  <= '0;
        r_div  <= '0;
      end else if (r_state == S_ISSUE) begin
        r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
        if (w_issue) begin
          pix_x     <= r_xacc;
          pix_y     <= r_yacc;
          pix_valid <= 1'b1;
          // End of row: rewind x to the window origin, step y down a row
          if (r_col == COL_MAX) begin
            r_col  <= '0;
            r_xacc <= r_sx;
            r_row  <= r_row + 1'b1;
            r_yacc <= r_yacc + r_sty;
          end else begin
            r_col  <= r_col + 1'b1;
            r_xacc <= r_xacc + r_stx;
          end
        end
      end

      if (w_accept) begin
        r_wcnt <= '0;
      end else if (w_tail) begin
        wr_en   <= 1'b1;
        wr_addr <= r_wcnt[ADDR_W-1:0];
        wr_data <= div_in[7] ? 7'h7f : div_in[6:0];
        r_wcnt  <= r_wcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fractal_scheduler.sv
// Bench for fractal_scheduler: table of small frames, scoreboarded writes,
// plus reset, config-isolation and back-to-back sequences.
module tb_fractal_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 3;
  localparam int P  = 5;
  localparam int AW = 4;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   cfg_startX = '0;
  logic [15:0]   cfg_startY = '0;
  logic [15:0]   cfg_stepX = '0;
  logic [15:0]   cfg_stepY = '0;
  logic [7:0]    div_in;
  logic [15:0]   pix_x;
  logic [15:0]   pix_y;
  logic          pix_valid;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic          wr_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fractal_scheduler #(
    .H_RES(H), .V_RES(V), .ISSUE_DIV(D),
    .PIPE_DEPTH(P), .ADDR_W(AW)
  ) dut (
    .Clk_100M(clk), .reset(reset), .start(start),
    .cfg_startX(cfg_startX), .cfg_startY(cfg_startY),
    .cfg_stepX(cfg_stepX), .cfg_stepY(cfg_stepY),
    .div_in(div_in), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [15:0] sx;
    logic [15:0] sy;
    logic [15:0] stx;
    logic [15:0] sty;
    bit          ramp;
    logic [7:0]  dval;
    logic [15:0] ex1;
    logic [15:0] eyl;
    int          ed0;
  } vec_t;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } sb_t;

  vec_t vt[5];
  sb_t  q[$];
  sb_t  e_sb;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pk = 0;
  int wcount = 0;
  int dcount = 0;
  int stray = 0;
  int last_wr_cyc = 0;
  bit watch = 1'b0;
  bit got;

  logic [15:0] m_sx, m_sy, m_stx, m_sty;
  bit          m_ramp;
  logic [7:0]  m_dval;
  logic [7:0]  nxt_div = 8'h00;
  logic [7:0]  v_div;
  logic [15:0] ex, ey;
  logic [7:0]  pd[P];
  int cap_x[N], cap_y[N], cap_d[N];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input logic [7:0] v);
    return (v > 8'd127) ? 127 : int'(v);
  endfunction

  // Stand-in for the divergence pipeline: fixed P-clock latency
  assign div_in = pd[P-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < P; i++) pd[i] <= 8'hEE;
    end else begin
      pd[0] <= pix_valid ? nxt_div : 8'hEE;
      for (int i = 1; i < P; i++) pd[i] <= pd[i-1];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (watch) begin
        if (wr_en || done || pix_valid) stray++;
      end else begin
        if (pix_valid) begin
          ex = m_sx + 16'(pk % H) * m_stx;
          ey = m_sy + 16'(pk / H) * m_sty;
          chk("pix_x", pix_x, ex);
          chk("pix_y", pix_y, ey);
          if (pk < N) begin
            cap_x[pk] = pix_x;
            cap_y[pk] = pix_y;
          end
          v_div = m_ramp ? 8'(pk) : m_dval;
          nxt_div = v_div;
          q.push_back('{pk, sat(v_div), cyc});
          pk++;
        end
        if (wr_en) begin
          if (q.size() == 0) begin
            chk("wr_unexpected", 1, 0);
          end else begin
            e_sb = q.pop_front();
            chk("wr_addr", wr_addr, e_sb.addr);
            chk("wr_data", wr_data, e_sb.data);
            chk("wr_latency", cyc - e_sb.cyc, P + 1);
          end
          if (wcount < N) cap_d[wcount] = wr_data;
          wcount++;
          last_wr_cyc = cyc;
        end
        if (done) begin
          dcount++;
          chk("done_after_last_wr", cyc - last_wr_cyc, 1);
        end
      end
    end
  end

  task automatic clr_model();
    pk = 0;
    wcount = 0;
    dcount = 0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      cap_x[i] = -1;
      cap_y[i] = -1;
      cap_d[i] = -1;
    end
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_startX = v.sx;
    cfg_startY = v.sy;
    cfg_stepX  = v.stx;
    cfg_stepY  = v.sty;
    m_sx   = v.sx;
    m_sy   = v.sy;
    m_stx  = v.stx;
    m_sty  = v.sty;
    m_ramp = v.ramp;
    m_dval = v.dval;
  endtask

  task automatic launch(input vec_t v);
    @(posedge clk);
    #1;
    set_cfg(v);
    clr_model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit disturb, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (disturb && c == 8) begin
        cfg_startX = 16'hDEAD;
        cfg_startY = 16'hBEEF;
        cfg_stepX  = 16'h0777;
        cfg_stepY  = 16'h0555;
        start = 1'b1;
      end
      if (disturb && c == 9) start = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input bit disturb);
    launch(v);
    wait_done(disturb, got);
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("write_count", wcount, N);
    chk("done_count", dcount, 1);
    chk("pixel_count", pk, N);
    chk("second_x", cap_x[1], v.ex1);
    chk("last_y", cap_y[N-1], v.eyl);
    chk("first_data", cap_d[0], v.ed0);
  endtask

  initial begin
    vt[0] = '{16'h1000, 16'h2000, 16'h0010, 16'h0100,
              1'b1, 8'd0, 16'h1010, 16'h2100, 0};
    vt[1] = '{16'h1000, 16'h2000, 16'h0010, 16'h0100,
              1'b0, 8'd200, 16'h1010, 16'h2100, 127};
    vt[2] = '{16'hFFF0, 16'h0000, 16'h0010, 16'h0001,
              1'b0, 8'd127, 16'h0000, 16'h0001, 127};
    vt[3] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000,
              1'b0, 8'd128, 16'h7FFF, 16'h7FFF, 127};
    vt[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 8'd5, 16'h0000, 16'h0000, 5};
    clr_model();

    repeat (3) @(negedge clk);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Reset in the middle of ISSUE
    launch(vt[0]);
    for (int c = 0; c < 100 && pk < 3; c++) @(negedge clk);
    chk("mid_reset_reached", pk, 3);
    #2;
    reset = 1'b1;
    watch = 1'b1;
    #1;
    chk("mrst_pix_x", pix_x, 0);
    chk("mrst_pix_y", pix_y, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_wr_data", wr_data, 0);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mrst_no_activity", stray, 0);
    chk("mrst_idle_busy", busy, 0);
    watch = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vt[i], 1'b0);

    // cfg churn and start pulses while busy
    run_frame(vt[0], 1'b1);

    // start held high across two frames
    @(posedge clk);
    #1;
    set_cfg(vt[0]);
    clr_model();
    start = 1'b1;
    wait_done(1'b0, got);
    chk("b2b_done1", got, 1);
    @(negedge clk);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_writes1", wcount, N);
    chk("b2b_dones1", dcount, 1);
    clr_model();
    @(negedge clk);
    chk("b2b_restart_busy", busy, 1);
    start = 1'b0;
    wait_done(1'b0, got);
    chk("b2b_done2", got, 1);
    @(negedge clk);
    chk("b2b_writes2", wcount, N);
    chk("b2b_dones2", dcount, 1);
    chk("b2b_first_data", cap_d[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_scheduler.md
Name: fractal_scheduler

Overview:
Frame-level sequencer for the Mandelbrot divergence pipeline. On a start request it latches the view window (origin, step), walks every pixel of an H_RES x V_RES frame in raster order and issues one pixel coordinate to pipeline stage 0 every ISSUE_DIV clocks. It tracks in-flight pixels through the PIPE_DEPTH-stage pipeline and turns each result leaving the tail into a frame-buffer write (address, data, enable). It signals frame completion once the last result has been written.

Parameters:
H_RES, 640, pixels per row
V_RES, 480, rows per frame
ISSUE_DIV, 6, clocks between pixel issues (>=1)
PIPE_DEPTH, 62, clocks from pix_valid to matching div_in at pipeline tail
ADDR_W, 19, frame-buffer address width (2^ADDR_W >= H_RES*V_RES)

Ports:
Clk_100M  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  frame request; sampled only in IDLE
cfg_startX  in  16  real coordinate of top-left pixel
cfg_startY  in  16  imaginary coordinate of top-left pixel
cfg_stepX  in  16  horizontal step
cfg_stepY  in  16  vertical step
div_in  in  8  divergence count from pipeline tail
pix_x  out  16  real coordinate to stage 0 (x and c1)
pix_y  out  16  imaginary coordinate to stage 0 (y and c2)
pix_valid  out  1  one-cycle strobe: pix_x/pix_y hold a new pixel
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  7  pixel value written
wr_en  out  1  one-cycle write strobe
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse after last write of frame

Behaviour:
- Reset values: pix_x=pix_y=0, pix_valid=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0. FSM=IDLE, all counters and the valid delay line cleared. Reset mid-frame abandons the frame with no further writes and no done pulse.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on start=1, latch the four cfg_* inputs into shadow registers. Clear col, row, div counter and write counter. Load the x accumulator with startX and the y accumulator with startY. Go to ISSUE; busy=1 from the next cycle. cfg_* changes while busy have no effect.
- ISSUE: div counter counts 0..ISSUE_DIV-1 and wraps.
  - When it equals ISSUE_DIV-1, register pix_x=x_acc, pix_y=y_acc and pix_valid=1 for one cycle.
  - Then advance: col<H_RES-1 -> col+1, x_acc+=stepX. Otherwise col=0, x_acc=startX, row+1, y_acc+=stepY.
  - First pix_valid is high ISSUE_DIV cycles after the start-accept edge.
  - After issuing pixel (H_RES-1, V_RES-1), go to DRAIN.
- Arithmetic: 16-bit two's-complement accumulation, wraps modulo 2^16 with no saturation. Accumulation matches startX + col*stepX truncated to 16 bits.
- Valid tracking: a PIPE_DEPTH-bit shift register shifts in pix_valid every clock. Its tail bit marks div_in as belonging to an issued pixel. Results return in issue order.
- Write-back:
  - When the tail bit is 1, the next edge sets wr_en=1, wr_addr=write counter, wr_data=div_in[6:0] (127 if div_in>127), then increments the write counter.
  - Otherwise wr_en=0 and wr_addr/wr_data hold.
  - Write latency: PIPE_DEPTH+1 clocks after the matching pix_valid.
  - Address = row*H_RES+col, computed via the sequential counter, with no multiplier.
- DRAIN: no issues. When the write counter reaches H_RES*V_RES, go to DONE.
- DONE: done=1 for one cycle, busy falls on the same edge that returns the FSM to IDLE. start high during DONE is ignored; start high in the following IDLE cycle begins a new frame.
- start asserted while busy: ignored (no queueing).
- ISSUE_DIV < PIPE_DEPTH is legal: pipeline holds multiple pixels, wr_en spacing equals ISSUE_DIV.

Test Plan:
- Reset: assert reset mid-ISSUE (H_RES=4,V_RES=2) -> all outputs 0 immediately, no wr_en/done afterward; FSM accepts start next.
- Small frame H_RES=4,V_RES=2,ISSUE_DIV=3,PIPE_DEPTH=5, startX=0x1000,startY=0x2000,stepX=0x0010,stepY=0x0100 -> 8 pix_valid pulses 3 cycles apart. Coordinates are (0x1000,0x2000),(0x1010,0x2000),(0x1020,..),(0x1030,..), then (0x1000,0x2100)...(0x1030,0x2100).
- Write-back, same config, div_in = tail-aligned count 0..7 -> wr_addr 0..7 with wr_data 0..7, each wr_en 6 cycles after its pix_valid. done pulses one cycle after wr_addr=7 write; busy low next cycle.
- Saturation/wrap: div_in=200 -> wr_data=127. startX=0xFFF0, stepX=0x0010 -> second pixel x=0x0000.
- Config isolation: change cfg_* and pulse start mid-frame -> coordinates unchanged, no restart, exactly H_RES*V_RES writes.
- Back-to-back: start held high continuously -> new frame begins in the IDLE cycle after done, with a 1-cycle gap between frames and write counter restarting at 0.
